uart_echo_responder: RTL and testbench
======================================

Name: uart_echo_responder

Overview:
- Serial-side peer for the team's UART transmitter/receiver pair; sits on the far end of the tx/rx line.
- Receives 16x-oversampled UART frames on `rx` and buffers good bytes in a small FIFO.
- Retransmits buffered bytes on `tx` in arrival order.
- Used as a loopback/echo target for link bring-up and for on-board testing of the host-side UART.

Parameters:
- DBIT, 8, data bits per frame, LSB first.
- SB_TICK, 16, ticks in the stop bit (16 means 1 stop bit).
- DATA_WIDTH, 8, FIFO word width; must equal DBIT.
- ADDR_WIDTH, 2, FIFO address width; depth is 2^ADDR_WIDTH (4).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- dvsr  input  11  baud divisor; sample tick every dvsr+1 clocks.
- rx  input  1  serial in; idles high.
- tx  output  1  serial out; idles high.
- tx_hold  input  1  1 = do not start a new TX frame (flow control).
- echo_busy  output  1  TX FSM not idle, or FIFO not empty.
- frame_err  output  1  1-cycle pulse on a bad stop bit.
- ovf  output  1  1-cycle pulse when a good byte is dropped because the FIFO is full.
- rx_count  output  8  count of good bytes received; wraps 255->0.

Behaviour:
- Reset (reset=0, async): tx=1, echo_busy=0, frame_err=0, ovf=0, rx_count=0, FIFO empty, both FSMs IDLE, tick counter 0.
  - Reset asserted mid-frame aborts immediately; tx goes to 1 in the same cycle, without waiting for a clock.
- Tick generator:
  - Counter counts 0..dvsr; `tick`=1 for one clk when count==dvsr, then the counter wraps to 0.
  - dvsr=0 gives a tick every clock.
  - RX and TX share the tick.
- rx is double-flopped before use.
- RX FSM: IDLE, START, DATA, STOP.
  - IDLE: synced rx==0 -> START, s=0.
  - START: on tick, s++; at s==7 resample rx.
    - rx==0: clear s, enter DATA with n=0.
    - rx==1: glitch; return to IDLE, no flags.
  - DATA: on tick, s++; at s==15 shift rx into the MSB of the shift register (LSB-first assembly) and clear s.
    - After DBIT bits -> STOP.
  - STOP: wait SB_TICK ticks, then sample rx.
    - rx==1: good byte; push to FIFO (or drop with ovf if full) and increment rx_count. The byte is counted even when dropped.
    - rx==0: pulse frame_err; discard the byte; rx_count unchanged.
    - Either way -> IDLE.
- FIFO:
  - 2^ADDR_WIDTH entries; full/empty from pointer comparison with an extra wrap bit.
  - Push when full: data dropped and ovf pulses, unless a pop occurs in the same cycle, in which case the push is accepted.
  - Pop when empty never occurs.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty and tx_hold==0, pop the head into the shift register and go to START.
  - START: tx=0 for 16 ticks.
  - DATA: tx=LSB, shift right every 16 ticks, DBIT bits.
  - STOP: tx=1 for SB_TICK ticks -> IDLE.
  - tx is registered.
  - tx_hold only gates the IDLE->START transition; a frame already in progress always completes.
- Latency:
  - The first TX start bit begins on the first clk after the push when TX is IDLE and tx_hold==0.
  - Tick phase may add up to dvsr+1 clocks.
- RX and TX run fully concurrently; receive and transmit overlap freely.

Optional Feature:
- UART_ECHO_CASE_EN defined: bytes 0x41-0x5A and 0x61-0x7A have bit 5 inverted at pop time, so ASCII letter case is swapped. All other bytes pass unchanged.
- Undefined: bytes are echoed bit-exact. No case logic is synthesised.

Test Plan:
- dvsr=3, send 0x55 (64-clk bits, 1 stop) -> rx_count=1; tx emits start, bits 1,0,1,0,1,0,1,0, stop; echo_busy 1 during the frame, 0 after.
- rx low for 16 clks (4 ticks), then high -> no push, rx_count=0, frame_err=0, tx stays 1.
- Send 0xA3 with stop bit=0 -> exactly one frame_err pulse; rx_count=0; no TX frame.
- tx_hold=1, send 0x01..0x05 -> ovf pulses once on 0x05; rx_count=5; release tx_hold -> echoes 0x01,0x02,0x03,0x04 in order, then echo_busy=0.
- Assert reset during TX data bit 3 of 0xF0 -> tx=1 before the next clk edge; after release rx_count=0, echo_busy=0, no further tx activity.
- With UART_ECHO_CASE_EN, send 0x61, 0x5B -> echoes 0x41, 0x5B; without the macro -> 0x61, 0x5B.

Source files
------------

// File: rtl/uart_echo_responder_if.sv
// rtl/uart_echo_responder_if.sv - serial link bundle between a host UART and the echo responder
interface uart_echo_responder_if;
  logic rx;
  logic tx;
  logic tx_hold;

  modport slave  (input rx, input tx_hold, output tx);
  modport master (output rx, output tx_hold, input tx);
endinterface

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - 16x-oversampled UART receiver, small FIFO and transmitter echoing good bytes
// Define UART_ECHO_CASE_EN to swap ASCII letter case on the echoed bytes.
module uart_echo_responder #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          dvsr,
  uart_echo_responder_if.slave link,
  output logic                 echo_busy,
  output logic                 frame_err,
  output logic                 ovf,
  output logic [7:0]           rx_count
);
  localparam int            NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [3:0]    S_MID   = 4'd7;
  localparam logic [3:0]    S_END   = 4'd15;
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [10:0] tcnt_q;
  logic        tick;
  logic        rx_meta_q, rx_sync_q;

  assign tick = (tcnt_q == dvsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q    <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      tcnt_q    <= tick ? 11'd0 : tcnt_q + 11'd1;
      rx_meta_q <= link.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver
  state_t          rx_state_q, rx_state_d;
  logic [3:0]      rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            rx_good, rx_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    unique case (rx_state_q)
      IDLE: if (!rx_sync_q) begin
        rx_state_d = START;
        rx_s_d     = '0;
      end
      START: if (tick) begin
        if (rx_s_q == S_MID) begin
          rx_s_d     = '0;
          rx_n_d     = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          rx_s_d = rx_s_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        if (rx_s_q == S_END) begin
          rx_s_d = '0;
          rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
          if (rx_n_q == N_LAST) rx_state_d = STOP;
          else                  rx_n_d     = rx_n_q + NW'(1);
        end else begin
          rx_s_d = rx_s_q + 4'd1;
        end
      end
      STOP: if (tick) begin
        if (rx_s_q == SB_LAST) rx_state_d = IDLE;
        else                   rx_s_d     = rx_s_q + 4'd1;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    if (rx_state_q == STOP && tick && rx_s_q == SB_LAST) begin
      rx_good = rx_sync_q;
      rx_bad  = !rx_sync_q;
    end
  end

  // FIFO with an extra wrap bit on each pointer to tell full from empty
  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH:0]   wptr_q, rptr_q;
  logic                  fifo_empty, fifo_full, wr_en, pop;
  logic [DATA_WIDTH-1:0] head, pop_data;
  logic [7:0]            rx_count_q;
  logic                  frame_err_q, ovf_q;
  state_t                tx_state_q, tx_state_d;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                      (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  assign pop        = (tx_state_q == IDLE) && !fifo_empty && !link.tx_hold;
  assign wr_en      = rx_good && (!fifo_full || pop);
  assign head       = mem_q[rptr_q[ADDR_WIDTH-1:0]];

`ifdef UART_ECHO_CASE_EN
  always_comb begin
    pop_data = head;
    if ((head >= 8'h41 && head <= 8'h5A) || (head >= 8'h61 && head <= 8'h7A))
      pop_data[5] = ~head[5];
  end
`else
  assign pop_data = head;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= rx_b_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rx_count_q  <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (wr_en)   wptr_q     <= wptr_q + 1'b1;
      if (pop)     rptr_q     <= rptr_q + 1'b1;
      if (rx_good) rx_count_q <= rx_count_q + 8'd1;
      frame_err_q <= rx_bad;
      ovf_q       <= rx_good && fifo_full && !pop;
    end
  end

  // Transmitter
  logic [3:0]      tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    unique case (tx_state_q)
      IDLE: if (pop) begin
        tx_state_d = START;
        tx_s_d     = '0;
        tx_b_d     = pop_data;
      end
      START: if (tick) begin
        if (tx_s_q == S_END) begin
          tx_state_d = DATA;
          tx_s_d     = '0;
          tx_n_d     = '0;
        end else begin
          tx_s_d = tx_s_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        if (tx_s_q == S_END) begin
          tx_s_d = '0;
          tx_b_d = tx_b_q >> 1;
          if (tx_n_q == N_LAST) tx_state_d = STOP;
          else                  tx_n_d     = tx_n_q + NW'(1);
        end else begin
          tx_s_d = tx_s_q + 4'd1;
        end
      end
      STOP: if (tick) begin
        if (tx_s_q == SB_LAST) tx_state_d = IDLE;
        else                   tx_s_d     = tx_s_q + 4'd1;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx stays a clean register output
  always_comb begin
    tx_d = 1'b1;
    unique case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign link.tx   = tx_q;
  assign echo_busy = (tx_state_q != IDLE) || !fifo_empty;
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;
  assign rx_count  = rx_count_q;
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - scoreboard bench: host UART sends frames, a monitor decodes the echo
module tb_uart_echo_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        echo_busy, frame_err, ovf;
  logic [7:0]  rx_count;

  uart_echo_responder_if link();

  uart_echo_responder dut (
    .clk       (clk),
    .reset     (reset),
    .dvsr      (dvsr),
    .link      (link),
    .echo_busy (echo_busy),
    .frame_err (frame_err),
    .ovf       (ovf),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  int         p = 4;
  bit         mon_abort = 1'b0;
  int         model_rx_cnt = 0;
  int         backlog = 0;
  int         fe_exp = 0, ovf_exp = 0;
  int         fe_seen = 0, ovf_seen = 0;
  time        tx_fall_t = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_CASE_EN
    if ((b >= "A" && b <= "Z") || (b >= "a" && b <= "z")) return b ^ 8'h20;
`endif
    return b;
  endfunction

  // Reference: good bytes are counted; with the line held, only four fit before bytes are lost
  task automatic send_frame(input logic [7:0] b, input bit good);
    if (good) begin
      model_rx_cnt = (model_rx_cnt + 1) % 256;
      if (link.tx_hold) begin
        if (backlog < 4) begin exp_q.push_back(echo_of(b)); backlog++; end
        else ovf_exp++;
      end else begin
        exp_q.push_back(echo_of(b));
      end
    end else begin
      fe_exp++;
    end
    link.rx = 1'b0;
    repeat (16 * p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      link.rx = b[i];
      repeat (16 * p) @(negedge clk);
    end
    if (good) begin
      link.rx = 1'b1;
      repeat (16 * p) @(negedge clk);
    end else begin
      link.rx = 1'b0;
      repeat (12 * p) @(negedge clk);
      link.rx = 1'b1;
      repeat (24 * p) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((echo_busy !== 1'b0 || exp_q.size() != 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check({name, " drain within budget"}, int'(k < 20000), 1);
    check({name, " echo_busy after drain"}, echo_busy, 0);
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (ovf === 1'b1) ovf_seen++;
  end

  always @(negedge link.tx) tx_fall_t = $time;

  // Host-side receiver: samples each echoed bit near its centre
  initial begin
    logic [7:0] got, want;
    logic       stop;
    int         pp;
    forever begin
      @(negedge clk);
      if (link.tx === 1'b0) begin
        pp = p;
        mon_abort = 1'b0;
        repeat (24 * pp) @(negedge clk);
        got[0] = link.tx;
        for (int i = 1; i < 8; i++) begin
          repeat (16 * pp) @(negedge clk);
          got[i] = link.tx;
        end
        repeat (16 * pp) @(negedge clk);
        stop = link.tx;
        if (!mon_abort) begin
          check("echo stop bit", stop, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL echo unexpected: got byte 0x%02h, none expected", got);
          end else begin
            want = exp_q.pop_front();
            check("echo byte", got, want);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, %0d echoes outstanding", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    int lows;
    reset = 1'b0;
    dvsr = 11'd3;
    p = 4;
    link.rx = 1'b1;
    link.tx_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", link.tx, 1);
    check("reset echo_busy", echo_busy, 0);
    check("reset rx_count", rx_count, 0);
    check("reset frame_err", frame_err, 0);
    check("reset ovf", ovf, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h55, 1'b1);
    check("echo_busy during 0x55 echo", echo_busy, 1);
    check("rx_count after 0x55", rx_count, model_rx_cnt);
    wait_drain("0x55");

    link.rx = 1'b0;
    repeat (16) @(negedge clk);
    link.rx = 1'b1;
    repeat (40 * p) @(negedge clk);
    check("rx_count after glitch", rx_count, model_rx_cnt);
    check("frame_err after glitch", fe_seen, fe_exp);
    check("echo_busy after glitch", echo_busy, 0);

    send_frame(8'hA3, 1'b0);
    repeat (16 * p) @(negedge clk);
    check("frame_err pulses after bad stop", fe_seen, fe_exp);
    check("rx_count after bad stop", rx_count, model_rx_cnt);
    check("echo_busy after bad stop", echo_busy, 0);

    link.tx_hold = 1'b1;
    backlog = 0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    check("ovf pulses with hold", ovf_seen, ovf_exp);
    check("rx_count with hold", rx_count, model_rx_cnt);
    check("echo_busy while held", echo_busy, 1);
    check("tx idle while held", link.tx, 1);
    link.tx_hold = 1'b0;
    backlog = 0;
    wait_drain("held burst");

    send_frame(8'h61, 1'b1);
    send_frame(8'h5B, 1'b1);
    wait_drain("case pair");

    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0));
      repeat ($urandom_range(0, 3) * 16 * p) @(negedge clk);
    end
    wait_drain("random");
    check("rx_count after random", rx_count, model_rx_cnt);
    check("frame_err after random", fe_seen, fe_exp);

    send_frame(8'hF0, 1'b1);
    check("echo_busy at 0xF0 echo", echo_busy, 1);
    while ($time < tx_fall_t + 72 * p * 10) @(negedge clk);
    #2;
    check("tx low in data bit 3", link.tx, 0);
    reset = 1'b0;
    #1;
    check("tx high on async reset", link.tx, 1);
    mon_abort = 1'b1;
    exp_q.delete();
    model_rx_cnt = 0;
    backlog = 0;
    dvsr = 11'd0;
    p = 1;
    repeat (3) @(negedge clk);
    check("rx_count in reset", rx_count, 0);
    check("echo_busy in reset", echo_busy, 0);
    reset = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (link.tx !== 1'b1) lows++;
    end
    check("tx quiet after reset", lows, 0);
    check("echo_busy after reset", echo_busy, 0);
    check("rx_count after reset", rx_count, 0);

    for (int k = 0; k < 6; k++) send_frame(8'($urandom), 1'b1);
    wait_drain("dvsr 0");
    check("rx_count at dvsr 0", rx_count, model_rx_cnt);
    check("ovf total", ovf_seen, ovf_exp);
    check("frame_err total", fe_seen, fe_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
